// File: rtl/lsu_pipe.sv
// lsu_pipe: single-outstanding load/store unit for the MEM stage.
//   Accepts one instruction in IDLE, issues a word-aligned memory request
//   in REQ, waits for read data in RESP, and registers the writeback.
//   Non-memory ops are passed straight through to writeback one cycle later.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   valid_i, load_valid_i,
//   store_valid_i, funct3_i,
//   rd_i, addr_i, store_data_i  instruction from EX
//   stall_o                     hold upstream
//   dmem_req_o, dmem_we_o,
//   dmem_addr_o, dmem_be_o,
//   dmem_wdata_o                memory request channel
//   dmem_gnt_i, dmem_rvalid_i,
//   dmem_rdata_i                memory grant / response
//   rd_o, rd_data_o, rd_wen_o   writeback port (rd_wen_o is a pulse)
//   misalign_o                  misaligned-access pulse
module lsu_pipe #(
  parameter int ADDR_W = 32,
  parameter int RF_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              load_valid_i,
  input  logic              store_valid_i,
  input  logic [2:0]        funct3_i,
  input  logic [RF_AW-1:0]  rd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       store_data_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic [RF_AW-1:0]  rd_o,
  output logic [31:0]       rd_data_o,
  output logic              rd_wen_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t state, state_nx;

  logic [RF_AW-1:0]  cap_rd;
  logic [ADDR_W-1:0] cap_addr;
  logic [2:0]        cap_f3;
  logic              cap_load;
  logic [31:0]       cap_data;

  logic        is_mem;
  logic        mis_c;
  logic        accept_mem;
  logic        active;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;

  // Size is taken from funct3[1:0]: 00 byte, 01 half, otherwise word.
  always_comb begin
    mis_c = 1'b0;
    unique case (funct3_i[1:0])
      2'b00:   mis_c = 1'b0;
      2'b01:   mis_c = addr_i[0];
      default: mis_c = |addr_i[1:0];
    endcase
  end

  assign is_mem     = load_valid_i | store_valid_i;
  assign accept_mem = (state == IDLE) && valid_i && is_mem && !mis_c;
  assign stall_o    = !rst && ((state != IDLE) || accept_mem);
  assign active     = !rst && (state == REQ);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept_mem) state_nx = REQ;
      REQ:  if (dmem_gnt_i) state_nx = cap_load ? RESP : IDLE;
      RESP: if (dmem_rvalid_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request channel is driven only from captured state, zero outside REQ.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    if (active) begin
      dmem_req_o  = 1'b1;
      dmem_we_o   = !cap_load;
      dmem_addr_o = {cap_addr[ADDR_W-1:2], 2'b00};
      if (cap_load) begin
        dmem_be_o = 4'b1111;
      end else begin
        unique case (cap_f3[1:0])
          2'b00: begin
            dmem_be_o    = 4'b0001 << cap_addr[1:0];
            dmem_wdata_o = {4{cap_data[7:0]}};
          end
          2'b01: begin
            dmem_be_o    = cap_addr[1] ? 4'b1100 : 4'b0011;
            dmem_wdata_o = {2{cap_data[15:0]}};
          end
          default: begin
            dmem_be_o    = 4'b1111;
            dmem_wdata_o = cap_data;
          end
        endcase
      end
    end
  end

  // Load lane extraction; funct3[2] selects zero extension.
  assign lane_b = dmem_rdata_i[{cap_addr[1:0], 3'b000} +: 8];
  assign lane_h = cap_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  always_comb begin
    load_val = dmem_rdata_i;
    unique case (cap_f3[1:0])
      2'b00:   load_val = cap_f3[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_val = cap_f3[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_o       <= '0;
      rd_data_o  <= '0;
      rd_wen_o   <= 1'b0;
      misalign_o <= 1'b0;
      cap_rd     <= '0;
      cap_addr   <= '0;
      cap_f3     <= '0;
      cap_load   <= 1'b0;
      cap_data   <= '0;
    end else begin
      state      <= state_nx;
      rd_wen_o   <= 1'b0;
      misalign_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid_i) begin
            if (!is_mem) begin
              rd_o      <= rd_i;
              rd_data_o <= 32'(addr_i);
              rd_wen_o  <= (rd_i != '0);
            end else if (mis_c) begin
              misalign_o <= 1'b1;
            end else begin
              cap_rd   <= rd_i;
              cap_addr <= addr_i;
              cap_f3   <= funct3_i;
              cap_load <= load_valid_i;
              cap_data <= store_data_i;
            end
          end
        end
        RESP: begin
          if (dmem_rvalid_i) begin
            rd_o      <= cap_rd;
            rd_data_o <= load_val;
            rd_wen_o  <= (cap_rd != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe: a transaction-level model sets the expected
// value of every output each cycle; one process compares at the negedge.
module tb_lsu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, ld, st;
  logic [2:0]  f3;
  logic [4:0]  rd_in;
  logic [31:0] addr, sdata;
  logic        stall, req, we;
  logic [31:0] maddr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic [4:0]  rd_out;
  logic [31:0] rd_data;
  logic        rd_wen, mis;

  always #5 clk = ~clk;

  lsu_pipe #(.ADDR_W(32), .RF_AW(5)) dut (
    .clk(clk), .rst(rst), .valid_i(valid), .load_valid_i(ld),
    .store_valid_i(st), .funct3_i(f3), .rd_i(rd_in), .addr_i(addr),
    .store_data_i(sdata), .stall_o(stall), .dmem_req_o(req),
    .dmem_we_o(we), .dmem_addr_o(maddr), .dmem_be_o(be),
    .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
    .dmem_rdata_i(rdata), .rd_o(rd_out), .rd_data_o(rd_data),
    .rd_wen_o(rd_wen), .misalign_o(mis)
  );

  int total = 0;
  int bad = 0;
  bit chk = 0;

  logic        e_stall, e_req, e_we, e_wen, e_mis;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          req_cnt;
  logic [3:0]  last_be;
  logic [31:0] last_wdata, last_addr;
  logic        last_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("stall", 32'(stall), 32'(e_stall));
      check("req", 32'(req), 32'(e_req));
      check("we", 32'(we), 32'(e_we));
      check("maddr", maddr, e_addr);
      check("be", 32'(be), 32'(e_be));
      check("wdata", wdata, e_wdata);
      check("rd_wen", 32'(rd_wen), 32'(e_wen));
      check("misalign", 32'(mis), 32'(e_mis));
      check("rd", 32'(rd_out), 32'(m_rd));
      check("rd_data", rd_data, m_data);
      if (req === 1'b1) begin
        req_cnt++;
        last_be = be;
        last_wdata = wdata;
        last_addr = maddr;
        last_we = we;
      end
    end
  end

  function automatic int acc_size(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit misal(input logic [2:0] f, input logic [31:0] a);
    return (a % acc_size(f)) != 0;
  endfunction

  function automatic logic [3:0] st_be(input logic [2:0] f, input logic [31:0] a);
    int sz = acc_size(f);
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] st_wdata(input logic [2:0] f, input logic [31:0] d);
    int sz = acc_size(f);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ld_val(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] r);
    logic [31:0] v;
    int sz = acc_size(f);
    v = r >> (8 * (a % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f[2] && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f[2] && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  task automatic exp_idle();
    e_stall = 0; e_req = 0; e_we = 0; e_addr = '0; e_be = '0;
    e_wdata = '0; e_wen = 0; e_mis = 0;
  endtask

  task automatic clr_in();
    valid = 0; ld = 0; st = 0; f3 = '0; rd_in = '0; addr = '0;
    sdata = '0; gnt = 0; rvalid = 0; rdata = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] a);
    nxt(); clr_in(); exp_idle();
    valid = 1; rd_in = rd; addr = a;
    nxt(); clr_in(); exp_idle();
    e_wen = (rd != 0); m_rd = rd; m_data = a;
  endtask

  // kind: 0 store, 1 load, 2 both flags set (behaves as load).
  // gdly: extra REQ cycles before gnt; rvdly: RESP cycle index of rvalid.
  task automatic mem_op(input int kind, input logic [2:0] f, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int gdly, input int rvdly, input logic [31:0] rdat);
    bit is_load = (kind != 0);
    nxt(); clr_in(); exp_idle();
    valid = 1; ld = (kind != 0); st = (kind != 1); f3 = f; rd_in = rd;
    addr = a; sdata = sd;
    if (misal(f, a)) begin
      nxt(); clr_in(); exp_idle();
      e_mis = 1;
      return;
    end
    e_stall = 1;
    for (int k = 0; k <= gdly; k++) begin
      nxt(); clr_in(); exp_idle();
      // unrelated instruction held upstream must be ignored
      valid = 1; st = 1; f3 = 3'b010; rd_in = 5'd31;
      addr = 32'hDEAD_BEE0; sdata = 32'h1234_5678;
      gnt = (k == gdly);
      rvalid = (k == gdly);
      rdata = 32'hFFFF_FFFF;
      e_stall = 1; e_req = 1; e_we = !is_load; e_addr = a & ~32'h3;
      e_be = is_load ? 4'hF : st_be(f, a);
      e_wdata = is_load ? 32'h0 : st_wdata(f, sd);
    end
    if (!is_load) begin
      nxt(); clr_in(); exp_idle();
      return;
    end
    for (int j = 1; j <= rvdly; j++) begin
      nxt(); clr_in(); exp_idle();
      e_stall = 1;
      rvalid = (j == rvdly);
      rdata = rdat;
    end
    nxt(); clr_in(); exp_idle();
    e_wen = (rd != 0); m_rd = rd; m_data = ld_val(f, a, rdat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in(); exp_idle();
    rst = 1; m_rd = '0; m_data = '0; req_cnt = 0;
    last_be = '0; last_wdata = '0; last_addr = '0; last_we = 0;
    valid = 1; ld = 1; f3 = 3'b010; addr = 32'h100;  // ignored under reset
    nxt();
    chk = 1;
    #1;
    check("lit_rst_rd", 32'(rd_out), 32'h0);
    check("lit_rst_wen", 32'(rd_wen), 32'h0);
    check("lit_rst_stall", 32'(stall), 32'h0);
    nxt();
    rst = 0; clr_in();

    // LB from 0x103, byte 0x80 sign-extends
    mem_op(1, 3'b000, 5'd5, 32'h103, 32'h0, 0, 1, 32'h80FF_0000);
    #1;
    check("lit_lb_wen", 32'(rd_wen), 32'h1);
    check("lit_lb_rd", 32'(rd_out), 32'd5);
    check("lit_lb_data", rd_data, 32'hFFFF_FF80);

    // SH to 0x22
    req_cnt = 0;
    mem_op(0, 3'b001, 5'd7, 32'h22, 32'h0000_BEEF, 0, 0, 32'h0);
    #1;
    check("lit_sh_addr", last_addr, 32'h20);
    check("lit_sh_be", 32'(last_be), 32'hC);
    check("lit_sh_wdata", last_wdata, 32'hBEEF_BEEF);
    check("lit_sh_we", 32'(last_we), 32'h1);
    check("lit_sh_wen", 32'(rd_wen), 32'h0);

    // LW misaligned
    req_cnt = 0;
    mem_op(1, 3'b010, 5'd9, 32'h41, 32'h0, 0, 1, 32'h0);
    #1;
    check("lit_lw_mis", 32'(mis), 32'h1);
    nxt(); clr_in(); exp_idle();
    #1;
    check("lit_lw_noreq", 32'(req_cnt), 32'd0);

    // LHU from 0x2, gnt on third request cycle
    req_cnt = 0;
    mem_op(1, 3'b101, 5'd12, 32'h2, 32'h0, 2, 1, 32'h9ABC_1234);
    #1;
    check("lit_lhu_reqcyc", 32'(req_cnt), 32'd3);
    check("lit_lhu_data", rd_data, 32'h0000_9ABC);

    // reset while in RESP, then a late rvalid
    nxt(); clr_in(); exp_idle();
    valid = 1; ld = 1; f3 = 3'b000; rd_in = 5'd4; addr = 32'h10;
    e_stall = 1;
    nxt(); clr_in(); exp_idle();
    gnt = 1; e_stall = 1; e_req = 1; e_addr = 32'h10; e_be = 4'hF;
    nxt(); clr_in(); exp_idle();
    rst = 1;
    nxt(); clr_in(); exp_idle();
    rst = 0; rvalid = 1; rdata = 32'h7777_7777;
    m_rd = '0; m_data = '0;
    nxt(); clr_in(); exp_idle();
    #1;
    check("lit_rst_resp_wen", 32'(rd_wen), 32'h0);
    check("lit_rst_resp_data", rd_data, 32'h0);

    // ALU pass-through
    alu_op(5'd0, 32'h55);
    #1;
    check("lit_alu0_data", rd_data, 32'h55);
    check("lit_alu0_wen", 32'(rd_wen), 32'h0);
    alu_op(5'd3, 32'h55);
    #1;
    check("lit_alu3_wen", 32'(rd_wen), 32'h1);

    // further patterns checked by the model alone
    mem_op(0, 3'b000, 5'd1, 32'h201, 32'hCAFE_BAA5, 0, 0, 32'h0);  // SB lane 1
    mem_op(0, 3'b000, 5'd1, 32'h203, 32'h0000_003C, 1, 0, 32'h0);  // SB lane 3
    mem_op(0, 3'b010, 5'd2, 32'h300, 32'h0123_4567, 0, 0, 32'h0);  // SW
    mem_op(0, 3'b001, 5'd2, 32'h301, 32'h0000_1111, 0, 0, 32'h0);  // SH misaligned
    mem_op(1, 3'b001, 5'd8, 32'h402, 32'h8001_7FFF, 0, 2, 32'h8001_7FFF); // LH neg
    mem_op(1, 3'b100, 5'd9, 32'h501, 32'h0000_F000, 0, 1, 32'h0000_F000); // LBU
    mem_op(1, 3'b010, 5'd10, 32'h600, 32'h0, 1, 3, 32'hA5A5_5A5A);  // LW
    mem_op(2, 3'b010, 5'd11, 32'h700, 32'h0, 0, 1, 32'h1357_9BDF);  // both flags
    mem_op(1, 3'b000, 5'd0, 32'h800, 32'h0, 0, 1, 32'h0000_00AA);   // load to x0
    mem_op(1, 3'b101, 5'd13, 32'h903, 32'h0, 0, 1, 32'h0);          // LHU misaligned
    alu_op(5'd31, 32'hFFFF_0001);
    nxt(); clr_in(); exp_idle();
    nxt();

    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
